bus_dma: RTL and testbench

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma_pkg.sv | 33 +++
 rtl/bus_dma_regs.sv | 90 +++++++++
 rtl/bus_dma.sv | 142 ++++++++++++++
 tb/tb_bus_dma.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared encodings for the bus DMA: FSM states, register offsets and bit positions.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_GAP,
        ST_DONE
    } state_e;

    // Config register offsets
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_BURST    = 2;

    // STAT read bits
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_BURST   = 2;
    localparam int unsigned STAT_CNT_LSB = 8;

    localparam int unsigned REG_W = 8;

endpackage

// File: rtl/bus_dma_regs.sv
// Config register file (SRC/DST/LEN/burst) with combinational readback mux.
module bus_dma_regs
    import bus_dma_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_wr_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_din_i,
    output logic [DATA_W-1:0] cfg_dout_o,
    input  logic              busy_i,
    input  logic              done_i,
    input  logic [REG_W-1:0]  count_i,
    output logic [REG_W-1:0]  src_o,
    output logic [REG_W-1:0]  dst_o,
    output logic [REG_W-1:0]  len_o,
    output logic              burst_o,
    output logic              start_o,
    output logic              clr_done_o
);

    logic [REG_W-1:0] src_q, src_d;
    logic [REG_W-1:0] dst_q, dst_d;
    logic [REG_W-1:0] len_q, len_d;
    logic             burst_q, burst_d;
    logic             ctrl_wr;

    // Only the low byte of write data carries register content.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_din_i[DATA_W-1:REG_W];

    assign ctrl_wr    = cfg_wr_i && (cfg_addr_i == REG_CTRL);
    assign start_o    = ctrl_wr && cfg_din_i[CTRL_START] && !busy_i;
    assign clr_done_o = ctrl_wr && cfg_din_i[CTRL_CLR_DONE];

    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;
    assign burst_o = burst_q;

    // Next register contents: writes land only while the engine is idle.
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        burst_d = burst_q;
        if (cfg_wr_i && !busy_i) begin
            case (cfg_addr_i)
                REG_SRC:  src_d   = cfg_din_i[REG_W-1:0];
                REG_DST:  dst_d   = cfg_din_i[REG_W-1:0];
                REG_LEN:  len_d   = cfg_din_i[REG_W-1:0];
                default:  burst_d = cfg_din_i[CTRL_BURST];
            endcase
        end
    end

    // Register storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            burst_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    // Readback mux; STAT reflects live engine status.
    always_comb begin
        cfg_dout_o = '0;
        case (cfg_addr_i)
            REG_SRC: cfg_dout_o[REG_W-1:0] = src_q;
            REG_DST: cfg_dout_o[REG_W-1:0] = dst_q;
            REG_LEN: cfg_dout_o[REG_W-1:0] = len_q;
            default: begin
                cfg_dout_o[STAT_BUSY]              = busy_i;
                cfg_dout_o[STAT_DONE]              = done_i;
                cfg_dout_o[STAT_BURST]             = burst_q;
                cfg_dout_o[STAT_CNT_LSB +: REG_W]  = count_i;
            end
        endcase
    end

endmodule

// File: rtl/bus_dma.sv
// Single-channel bus DMA: copies LEN words from SRC to DST over an arbitrated bus.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_din,
    output logic [DATA_W-1:0] cfg_dout,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              irq
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [REG_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              done_q, done_d;

    logic [REG_W-1:0]  src_reg, dst_reg, len_reg;
    logic              burst, start, clr_done, busy;

    assign busy = (state_q != ST_IDLE);

    bus_dma_regs #(
        .DATA_W(DATA_W)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_wr_i   (cfg_wr),
        .cfg_addr_i (cfg_addr),
        .cfg_din_i  (cfg_din),
        .cfg_dout_o (cfg_dout),
        .busy_i     (busy),
        .done_i     (done_q),
        .count_i    (count_q),
        .src_o      (src_reg),
        .dst_o      (dst_reg),
        .len_o      (len_reg),
        .burst_o    (burst),
        .start_o    (start),
        .clr_done_o (clr_done)
    );

    // Next-state, datapath updates and bus outputs decoded from the current state.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        count_d   = count_q;
        buf_d     = buf_q;
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        m_dout    = '0;
        irq       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_d = ADDR_W'(src_reg);
                    dst_ptr_d = ADDR_W'(dst_reg);
                    count_d   = len_reg;
                    state_d   = (len_reg == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                m_req = 1'b1;
                if (m_grant) state_d = ST_RD;
            end
            ST_RD: begin
                m_req     = 1'b1;
                m_address = src_ptr_q;
                if (m_grant) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                m_req     = 1'b1;
                m_address = src_ptr_q;
                buf_d     = m_din;
                state_d   = ST_WR;
            end
            ST_WR: begin
                m_req     = 1'b1;
                m_wr      = 1'b1;
                m_address = dst_ptr_q;
                m_dout    = buf_q;
                if (m_grant) begin
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    count_d   = count_q - 8'd1;
                    if (count_q == 8'd1) state_d = ST_DONE;
                    else if (burst)      state_d = ST_RD;
                    else                 state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_REQ;
            end
            ST_DONE: begin
                irq     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Done flag: a clear in the same write as a start is applied before completion can set it.
    always_comb begin
        done_d = done_q;
        if (clr_done) done_d = 1'b0;
        if (state_d == ST_DONE && state_q != ST_DONE) done_d = 1'b1;
    end

    // Engine state registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            count_q   <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// Directed self-checking bench for bus_dma with a simple bus memory and arbiter model.
module tb_bus_dma;

    logic        clk;
    logic        reset_n;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_din;
    logic [31:0] cfg_dout;
    logic        m_req;
    logic        m_grant;
    logic        m_wr;
    logic [7:0]  m_address;
    logic [31:0] m_dout;
    logic [31:0] m_din;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bus_dma #(
        .ADDR_W(8),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_din   (cfg_din),
        .cfg_dout  (cfg_dout),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_din     (m_din),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unwritten memory words hold a pattern derived from their address.
    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    // Arbiter/memory model state (written only by the monitor block).
    logic [31:0] mem [0:255];
    logic [255:0] written = '0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int unsigned irq_cnt = 0, req_hi = 0, req_rises = 0, short_gaps = 0, viol = 0;
    int unsigned gl = 0, low_run = 0;
    logic        prev_req = 1'b0, prev_wr = 1'b0, prev_grant = 1'b1;
    logic [7:0]  prev_addr = '0;
    logic [31:0] pend = 32'hDEAD_BEEF;

    // Stall controls set by the tests.
    int unsigned req_hold = 0, wr_hold = 0;

    initial begin
        m_grant = 1'b1;
        m_din   = '0;
    end

    // Arbiter, memory and bus monitor, evaluated mid-cycle for the upcoming edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            gl         = 0;
            m_grant    = 1'b1;
            prev_req   = 1'b0;
            prev_wr    = 1'b0;
            prev_grant = 1'b1;
            pend       = 32'hDEAD_BEEF;
        end else begin
            if (m_req && !prev_req && req_hold > 0) gl = req_hold;
            if (m_wr && !prev_wr && wr_hold > 0)   gl = wr_hold;
            if (gl > 0) begin
                m_grant = 1'b0;
                gl--;
            end else begin
                m_grant = 1'b1;
            end
            // Read data appears one cycle after a granted read address.
            m_din = pend;
            pend  = (m_req && !m_wr && m_grant) ?
                    (written[m_address] ? mem[m_address] : pat(m_address)) : 32'hDEAD_BEEF;
            if (m_wr && m_grant) begin
                wr_addr.push_back(m_address);
                wr_data.push_back(m_dout);
                mem[m_address]     = m_dout;
                written[m_address] = 1'b1;
            end
            if (prev_wr && !prev_grant && !(m_wr && m_address == prev_addr)) viol++;
            if (irq) irq_cnt++;
            if (m_req) begin
                req_hi++;
                if (!prev_req) begin
                    req_rises++;
                    if (low_run == 1) short_gaps++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_req   = m_req;
            prev_wr    = m_wr;
            prev_grant = m_grant;
            prev_addr  = m_address;
        end
    end

    // Snapshot bases so each test looks at its own deltas.
    int unsigned b_irq, b_hi, b_rise, b_short, b_wr;
    task automatic snap();
        b_irq   = irq_cnt;
        b_hi    = req_hi;
        b_rise  = req_rises;
        b_short = short_gaps;
        b_wr    = wr_addr.size();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_din  = d;
        @(negedge clk);
        cfg_wr   = 1'b0;
        cfg_din  = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_dout;
    endtask

    task automatic wait_irq(input string name);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (irq_cnt > b_irq) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: irq seen=0 required=1", name);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n  = 1'b0;
        cfg_wr   = 1'b0;
        cfg_addr = '0;
        cfg_din  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, m_wr, irq} !== 3'b000 || m_address !== 8'h00 || m_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req/wr/irq=%b addr=%h dout=%h required 000/00/0",
                     {m_req, m_wr, irq}, m_address, m_dout);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h required 00000000", i, d);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        cfg_write(REG(0), 32'hFFFF_FF10);
        cfg_write(REG(1), 32'h0000_0080);
        cfg_write(REG(2), 32'h0000_0004);
        cfg_write(REG(3), 32'h0000_0004);
        read_reg(0, d); checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL reg_src: got %h required 00000010", d); end
        read_reg(1, d); checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL reg_dst: got %h required 00000080", d); end
        read_reg(2, d); checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL reg_len: got %h required 00000004", d); end
        read_reg(3, d); checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL reg_stat_burst: got %h required 00000004", d); end
    endtask

    function automatic logic [1:0] REG(input int i);
        return 2'(i);
    endfunction

    task automatic test_burst();
        logic [31:0] d;
        snap();
        cfg_write(3, 32'h5);
        read_reg(3, d); checks++;
        if (d !== 32'h405) begin errors++; $display("FAIL burst_stat_busy: got %h required 00000405", d); end
        cfg_write(0, 32'h55);     // ignored while busy
        cfg_write(3, 32'h1);      // start while busy, ignored
        wait_irq("burst");
        checks++;
        if (wr_addr.size() - b_wr != 4) begin
            errors++;
            $display("FAIL burst_nwrites: got %0d required 4", wr_addr.size() - b_wr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[b_wr+i] !== 8'(8'h80 + i) || wr_data[b_wr+i] !== pat(8'(8'h10 + i))) begin
                    errors++;
                    $display("FAIL burst_word%0d: addr=%h data=%h required addr=%h data=%h", i,
                             wr_addr[b_wr+i], wr_data[b_wr+i], 8'(8'h80 + i), pat(8'(8'h10 + i)));
                end
            end
        end
        checks++;
        if (irq_cnt - b_irq != 1) begin errors++; $display("FAIL burst_irq: got %0d required 1", irq_cnt - b_irq); end
        checks++;
        if (req_rises - b_rise != 1 || req_hi - b_hi != 13) begin
            errors++;
            $display("FAIL burst_req: rises=%0d hi=%0d required 1/13", req_rises - b_rise, req_hi - b_hi);
        end
        read_reg(3, d); checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL burst_stat_done: got %h required 00000006", d); end
        read_reg(0, d); checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL burst_src_locked: got %h required 00000010", d); end
    endtask

    task automatic test_gap();
        logic [31:0] d;
        snap();
        cfg_write(3, 32'h3);      // clear done + start, non-burst
        read_reg(3, d); checks++;
        if (d !== 32'h401) begin errors++; $display("FAIL gap_stat_busy: got %h required 00000401", d); end
        wait_irq("gap");
        checks++;
        if (wr_addr.size() - b_wr != 4) begin
            errors++;
            $display("FAIL gap_nwrites: got %0d required 4", wr_addr.size() - b_wr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[b_wr+i] !== 8'(8'h80 + i) || wr_data[b_wr+i] !== pat(8'(8'h10 + i))) begin
                    errors++;
                    $display("FAIL gap_word%0d: addr=%h data=%h required addr=%h data=%h", i,
                             wr_addr[b_wr+i], wr_data[b_wr+i], 8'(8'h80 + i), pat(8'(8'h10 + i)));
                end
            end
        end
        checks++;
        if (req_rises - b_rise != 4 || short_gaps - b_short != 3 || req_hi - b_hi != 16) begin
            errors++;
            $display("FAIL gap_req: rises=%0d gaps=%0d hi=%0d required 4/3/16",
                     req_rises - b_rise, short_gaps - b_short, req_hi - b_hi);
        end
        checks++;
        if (irq_cnt - b_irq != 1) begin errors++; $display("FAIL gap_irq: got %0d required 1", irq_cnt - b_irq); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [3];
        logic [31:0] d;
        exp_d[0] = pat(8'hFE);
        exp_d[1] = pat(8'hFF);
        exp_d[2] = pat(8'hFE);    // 0x00 was overwritten by the first word before being read
        cfg_write(0, 32'hFE);
        cfg_write(1, 32'h00);
        cfg_write(2, 32'h03);
        snap();
        cfg_write(3, 32'h7);
        wait_irq("wrap");
        checks++;
        if (wr_addr.size() - b_wr != 3) begin
            errors++;
            $display("FAIL wrap_nwrites: got %0d required 3", wr_addr.size() - b_wr);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[b_wr+i] !== 8'(i) || wr_data[b_wr+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL wrap_word%0d: addr=%h data=%h required addr=%h data=%h", i,
                             wr_addr[b_wr+i], wr_data[b_wr+i], 8'(i), exp_d[i]);
                end
            end
        end
        read_reg(3, d); checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL wrap_stat: got %h required 00000006", d); end
    endtask

    task automatic test_len0();
        logic [31:0] d;
        cfg_write(2, 32'h0);
        snap();
        cfg_write(3, 32'h3);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL len0_irq_on: got %b required 1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL len0_irq_off: got %b required 0", irq); end
        repeat (3) @(negedge clk);
        read_reg(3, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL len0_stat: got %h required 00000002", d); end
        checks++;
        if (req_hi != b_hi || irq_cnt - b_irq != 1 || wr_addr.size() != b_wr) begin
            errors++;
            $display("FAIL len0_bus: req_cycles=%0d irqs=%0d writes=%0d required 0/1/0",
                     req_hi - b_hi, irq_cnt - b_irq, wr_addr.size() - b_wr);
        end
    endtask

    task automatic test_grant_stall();
        cfg_write(0, 32'h40);
        cfg_write(1, 32'hC0);
        cfg_write(2, 32'h02);
        req_hold = 5;
        wr_hold  = 2;
        snap();
        cfg_write(3, 32'h3);
        wait_irq("stall");
        req_hold = 0;
        wr_hold  = 0;
        checks++;
        if (wr_addr.size() - b_wr != 2 ||
            wr_addr[b_wr] !== 8'hC0 || wr_data[b_wr] !== pat(8'h40) ||
            wr_addr[b_wr+1] !== 8'hC1 || wr_data[b_wr+1] !== pat(8'h41)) begin
            errors++;
            $display("FAIL stall_data: nwrites=%0d required 2 to C0/C1 with pat(40)/pat(41)",
                     wr_addr.size() - b_wr);
        end
        checks++;
        if (req_hi - b_hi != 22) begin errors++; $display("FAIL stall_req_cycles: got %0d required 22", req_hi - b_hi); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL stall_nogrant: violations=%0d required 0", viol); end
        checks++;
        if (irq_cnt - b_irq != 1) begin errors++; $display("FAIL stall_irq: got %0d required 1", irq_cnt - b_irq); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        bit found = 0;
        cfg_write(0, 32'h20);
        cfg_write(1, 32'hA0);
        cfg_write(2, 32'h04);
        wr_hold = 3;
        snap();
        cfg_write(3, 32'h5);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_wr && m_address == 8'hA1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_word2: seen=0 required 1"); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({m_req, m_wr, irq} !== 3'b000 || m_address !== 8'h00 || m_dout !== 32'h0) begin
            errors++;
            $display("FAIL abort_outputs: req/wr/irq=%b addr=%h dout=%h required 000/00/0",
                     {m_req, m_wr, irq}, m_address, m_dout);
        end
        read_reg(3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL abort_stat: got %h required 00000000", d); end
        wr_hold = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() - b_wr != 1 || irq_cnt != b_irq || m_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: writes=%0d irqs=%0d req=%b required 1/0/0",
                     wr_addr.size() - b_wr, irq_cnt - b_irq, m_req);
        end
        cfg_write(0, 32'h30);
        cfg_write(1, 32'hB0);
        cfg_write(2, 32'h02);
        snap();
        cfg_write(3, 32'h5);
        wait_irq("restart");
        checks++;
        if (wr_addr.size() - b_wr != 2 ||
            wr_addr[b_wr] !== 8'hB0 || wr_data[b_wr] !== pat(8'h30) ||
            wr_addr[b_wr+1] !== 8'hB1 || wr_data[b_wr+1] !== pat(8'h31) ||
            irq_cnt - b_irq != 1) begin
            errors++;
            $display("FAIL restart_data: nwrites=%0d irqs=%0d required 2 writes B0/B1 and 1 irq",
                     wr_addr.size() - b_wr, irq_cnt - b_irq);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_burst();
        test_gap();
        test_wrap();
        test_len0();
        test_grant_stall();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
